// File: rtl/rvfi_commit_checker.sv
// Checks each retired-instruction packet for order, PC continuity, x0 writes and target alignment.
// Optional macro RVFI_CHECK_X0_EN enables the x0-write check (code 3).
module rvfi_commit_checker #(
    parameter logic [31:0] RESET_PC  = 32'h00000060,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 commit,
    input  logic [63:0]          order,
    input  logic [31:0]          pc_rdata,
    input  logic [31:0]          pc_wdata,
    input  logic [4:0]           rd_addr,
    input  logic [31:0]          rd_wdata,
    input  logic                 trap,
    input  logic                 halt,
    output logic [31:0]          commit_count,
    output logic                 halted,
    output logic                 err,
    output logic [2:0]           err_code,
    output logic [31:0]          err_pc,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state;
    logic [63:0] expected_order;
    logic [31:0] expected_pc;
    logic        vld_p0;
    logic [2:0]  err_code_p0;
    logic        x0_fail_p0;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef RVFI_CHECK_X0_EN
    assign x0_fail_p0 = (rd_addr == 5'd0) && (rd_wdata != 32'd0);
`else
    logic unused_x0;
    assign x0_fail_p0 = 1'b0;
    assign unused_x0  = ^{rd_addr, rd_wdata};
`endif

    assign vld_p0 = commit;

    // Lowest failing code wins; after halt only the post-halt code applies.
    always_comb begin
        err_code_p0 = 3'd0;
        if (state == HALTED)
            err_code_p0 = 3'd5;
        else if (order != expected_order)
            err_code_p0 = 3'd1;
        else if (pc_rdata != expected_pc)
            err_code_p0 = 3'd2;
        else if (x0_fail_p0)
            err_code_p0 = 3'd3;
        else if ((pc_wdata[1:0] != 2'b00) && !trap)
            err_code_p0 = 3'd4;
    end

    // p0 -> p1: every output is registered one cycle after the strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            halted         <= 1'b0;
            commit_count   <= 32'd0;
            err            <= 1'b0;
            err_code       <= 3'd0;
            err_pc         <= 32'd0;
            err_cnt        <= '0;
            expected_order <= 64'd0;
            expected_pc    <= RESET_PC;
        end else if (vld_p0) begin
            commit_count <= commit_count + 32'd1;
            if (state == RUN) begin
                expected_order <= order + 64'd1;
                expected_pc    <= pc_wdata;
                if (halt) begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end
            end
            if (err_code_p0 != 3'd0) begin
                err_cnt <= sat_inc(err_cnt);
                if (!err) begin
                    err      <= 1'b1;
                    err_code <= err_code_p0;
                    err_pc   <= pc_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_rvfi_commit_checker.sv
// Bench for rvfi_commit_checker: directed steps plus random packets against a rule-level model.
module tb_rvfi_commit_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit;
    logic [63:0] order;
    logic [31:0] pc_rdata, pc_wdata, rd_wdata;
    logic [4:0]  rd_addr;
    logic        trap, halt;

    logic [31:0] commit_count, err_pc, commit_count2, err_pc2;
    logic        halted, err, halted2, err2;
    logic [2:0]  err_code, err_code2;
    logic [7:0]  err_cnt;
    logic [1:0]  err_cnt2;

    int vectors = 0;
    int miscompares = 0;

    // Model state
    logic [63:0] m_ord;
    logic [31:0] m_pc, m_cnt, m_epc;
    bit          m_halted, m_err;
    logic [2:0]  m_code;
    int          m_ecnt;

    always #5 clk = ~clk;

    rvfi_commit_checker dut (
        .clk(clk), .rst(rst), .commit(commit), .order(order),
        .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .trap(trap), .halt(halt), .commit_count(commit_count), .halted(halted),
        .err(err), .err_code(err_code), .err_pc(err_pc), .err_cnt(err_cnt)
    );

    rvfi_commit_checker #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .commit(commit), .order(order),
        .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .trap(trap), .halt(halt), .commit_count(commit_count2), .halted(halted2),
        .err(err2), .err_code(err_code2), .err_pc(err_pc2), .err_cnt(err_cnt2)
    );

    function automatic int clamp(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".commit_count"}, 64'(commit_count), 64'(m_cnt));
        chk({tag, ".halted"},       64'(halted),       64'(m_halted));
        chk({tag, ".err"},          64'(err),          64'(m_err));
        chk({tag, ".err_code"},     64'(err_code),     64'(m_code));
        chk({tag, ".err_pc"},       64'(err_pc),       64'(m_epc));
        chk({tag, ".err_cnt"},      64'(err_cnt),      64'(clamp(m_ecnt, 255)));
        chk({tag, ".err_cnt_w2"},   64'(err_cnt2),     64'(clamp(m_ecnt, 3)));
        chk({tag, ".err_code_w2"},  64'(err_code2),    64'(m_code));
    endtask

    task automatic drive_junk();
        order    = {$urandom, $urandom};
        pc_rdata = $urandom;
        pc_wdata = $urandom;
        rd_addr  = 5'($urandom);
        rd_wdata = $urandom;
        trap     = 1'($urandom);
        halt     = 1'($urandom);
    endtask

    task automatic model_reset();
        m_ord = 64'd0; m_pc = 32'h60; m_cnt = 32'd0; m_epc = 32'd0;
        m_halted = 0; m_err = 0; m_code = 3'd0; m_ecnt = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        commit = 1'b1;
        drive_junk();
        @(negedge clk);
        rst = 1'b0;
        commit = 1'b0;
        model_reset();
        check_all(tag);
    endtask

    task automatic commit_pkt(input logic [63:0] o, input logic [31:0] pr, input logic [31:0] pw,
                              input logic [4:0] ra, input logic [31:0] rw, input logic tr,
                              input logic hl, input string tag);
        logic [2:0] c;
        // Reference rules applied to the packet
        c = 3'd0;
        if (m_halted) c = 3'd5;
        else begin
            if (pw[1:0] != 2'b00 && !tr) c = 3'd4;
`ifdef RVFI_CHECK_X0_EN
            if (ra == 5'd0 && rw != 32'd0) c = 3'd3;
`endif
            if (pr != m_pc) c = 3'd2;
            if (o != m_ord) c = 3'd1;
            m_ord = o + 64'd1;
            m_pc  = pw;
            if (hl) m_halted = 1;
        end
        m_cnt = m_cnt + 32'd1;
        if (c != 3'd0) begin
            m_ecnt++;
            if (!m_err) begin m_err = 1; m_code = c; m_epc = pr; end
        end
        @(negedge clk);
        commit = 1'b1;
        order = o; pc_rdata = pr; pc_wdata = pw; rd_addr = ra; rd_wdata = rw; trap = tr; halt = hl;
        @(negedge clk);
        commit = 1'b0;
        drive_junk();
        check_all(tag);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            commit = 1'b0;
            drive_junk();
        end
    endtask

    initial begin
        rst = 1'b1;
        commit = 1'b0;
        drive_junk();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_reset("reset");

        // Clean three-instruction run
        commit_pkt(64'd0, 32'h60, 32'h64, 5'd1, 32'h5, 1'b0, 1'b0, "clean0");
        commit_pkt(64'd1, 32'h64, 32'h68, 5'd2, 32'h6, 1'b0, 1'b0, "clean1");
        idle_cycles(3);
        commit_pkt(64'd2, 32'h68, 32'h6c, 5'd3, 32'h7, 1'b0, 1'b0, "clean2");

        // Order gap, then resynchronised
        do_reset("reset_b");
        commit_pkt(64'd0, 32'h60, 32'h64, 5'd1, 32'h1, 1'b0, 1'b0, "gap0");
        commit_pkt(64'd2, 32'h64, 32'h68, 5'd1, 32'h1, 1'b0, 1'b0, "gap2");
        commit_pkt(64'd3, 32'h68, 32'h6c, 5'd1, 32'h1, 1'b0, 1'b0, "gap3");

        // PC mismatch alone, then together with order mismatch
        do_reset("reset_c");
        commit_pkt(64'd0, 32'h64, 32'h68, 5'd1, 32'h1, 1'b0, 1'b0, "pcbad");
        do_reset("reset_d");
        commit_pkt(64'd5, 32'h64, 32'h68, 5'd1, 32'h1, 1'b0, 1'b0, "pc_ord_bad");

        // Write to x0
        do_reset("reset_e");
        commit_pkt(64'd0, 32'h60, 32'h64, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0, "x0");

        // Misaligned target, with and without trap
        do_reset("reset_f");
        commit_pkt(64'd0, 32'h60, 32'h62, 5'd1, 32'h1, 1'b0, 1'b0, "align");
        do_reset("reset_g");
        commit_pkt(64'd0, 32'h60, 32'h62, 5'd1, 32'h1, 1'b1, 1'b0, "align_trap");
        commit_pkt(64'd1, 32'h62, 32'h100, 5'd1, 32'h1, 1'b0, 1'b0, "after_trap");

        // Halt, post-halt commit, then reset mid-stream
        do_reset("reset_h");
        commit_pkt(64'd0, 32'h60, 32'h64, 5'd1, 32'h1, 1'b0, 1'b1, "halt");
        commit_pkt(64'd1, 32'h64, 32'h68, 5'd1, 32'h1, 1'b0, 1'b0, "posthalt");
        do_reset("reset_mid");
        commit_pkt(64'd0, 32'h60, 32'h64, 5'd1, 32'h1, 1'b0, 1'b0, "after_rst");

        // Five errors: 2-bit counter saturates, first code held
        do_reset("reset_i");
        for (int i = 0; i < 5; i++)
            commit_pkt(64'd7, 32'h60, 32'h60, 5'd1, 32'h1, 1'b0, 1'b0, "sat");

        // Randomised runs
        for (int r = 0; r < 6; r++) begin
            do_reset("reset_rand");
            for (int k = 0; k < 40; k++) begin
                logic [63:0] o;
                logic [31:0] pr, pw, rw;
                logic [4:0]  ra;
                logic        tr, hl;
                o  = ($urandom_range(0, 9) == 0) ? m_ord + 64'($urandom_range(1, 3)) : m_ord;
                pr = ($urandom_range(0, 9) == 0) ? m_pc ^ 32'h10 : m_pc;
                pw = pr + 32'd4;
                if ($urandom_range(0, 9) == 0) pw = pw + 32'($urandom_range(1, 3));
                ra = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                rw = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
                tr = ($urandom_range(0, 7) == 0);
                hl = ($urandom_range(0, 29) == 0);
                commit_pkt(o, pr, pw, ra, rw, tr, hl, "rand");
                if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
